// File: rtl/ex_branch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_branch_stage_if
//  Description : Bus bundle between the execute stage driver and the
//                EX->MEM branch-resolution stage. Carries the EX-side op
//                payload, the MEM-side control inputs (stall/flush), the
//                registered MEM payload, the PC redirect and the performance
//                counters.
//  Modports    : master - drives the EX payload, stall_m and flush, and
//                         observes the MEM payload, redirect and counters
//                slave  - the stage itself (ex_branch_stage)
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_branch_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // EX-side op payload
    logic              valid_e;
    logic [DATA_W-1:0] aluresult_e;
    logic [3:0]        flags_e;       // {v,c,n,z}
    logic              branch_e;
    logic              jump_e;
    logic [2:0]        funct3_e;
    logic [DATA_W-1:0] pctarget_e;
    logic [DATA_W-1:0] writedata_e;
    logic [4:0]        rd_e;
    logic              regwrite_e;
    logic              memwrite_e;
    logic [1:0]        resultsrc_e;

    // Pipeline control
    logic              stall_m;
    logic              flush;

    // Registered MEM-side payload
    logic              valid_m;
    logic [DATA_W-1:0] aluresult_m;
    logic [DATA_W-1:0] writedata_m;
    logic [4:0]        rd_m;
    logic              regwrite_m;
    logic              memwrite_m;
    logic [1:0]        resultsrc_m;

    // PC redirect
    logic              redirect_m;
    logic [DATA_W-1:0] pctarget_m;

    // Performance counters
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output valid_e, aluresult_e, flags_e, branch_e, jump_e, funct3_e,
               pctarget_e, writedata_e, rd_e, regwrite_e, memwrite_e,
               resultsrc_e, stall_m, flush,
        input  valid_m, aluresult_m, writedata_m, rd_m, regwrite_m,
               memwrite_m, resultsrc_m, redirect_m, pctarget_m,
               br_count, taken_count
    );

    modport slave (
        input  valid_e, aluresult_e, flags_e, branch_e, jump_e, funct3_e,
               pctarget_e, writedata_e, rd_e, regwrite_e, memwrite_e,
               resultsrc_e, stall_m, flush,
        output valid_m, aluresult_m, writedata_m, rd_m, regwrite_m,
               memwrite_m, resultsrc_m, redirect_m, pctarget_m,
               br_count, taken_count
    );
endinterface
`default_nettype wire

// File: rtl/ex_branch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_branch_stage
//  Description : Execute-to-memory boundary stage. Resolves conditional
//                branches from the ALU {v,c,n,z} flags and unconditional
//                jumps, registers the EX->MEM payload, issues a registered
//                one-cycle PC redirect and squashes the single wrong-path op
//                that follows a taken branch/jump. Keeps saturating
//                resolved-branch and taken-branch performance counters.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high
//                bus    - ex_branch_stage_if.slave (EX payload in, stall_m,
//                         flush in, MEM payload / redirect / counters out)
//  Parameters  : DATA_W - result, write data and PC width
//                CNT_W  - performance counter width
//  Revision    : 1.0  initial release
// ============================================================================
module ex_branch_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ex_branch_stage_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Branch funct3 encodings
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t             r_state;

    logic               r_valid_m;
    logic [DATA_W-1:0]  r_aluresult_m;
    logic [DATA_W-1:0]  r_writedata_m;
    logic [4:0]         r_rd_m;
    logic               r_regwrite_m;
    logic               r_memwrite_m;
    logic [1:0]         r_resultsrc_m;
    logic               r_redirect_m;
    logic [DATA_W-1:0]  r_pctarget_m;
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_taken_count;

    logic               w_flag_v;
    logic               w_flag_c;
    logic               w_flag_n;
    logic               w_flag_z;
    logic               w_cond;
    logic               w_act;
    logic               w_resolve;
    logic               w_taken;
    logic               w_br_sat;
    logic               w_taken_sat;

    assign w_flag_v = bus.flags_e[3];
    assign w_flag_c = bus.flags_e[2];
    assign w_flag_n = bus.flags_e[1];
    assign w_flag_z = bus.flags_e[0];

    // Branch condition from the subtract flags of rs1 - rs2.
    // Signed less-than is n^v; unsigned less-than is a missing carry (~c).
    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3_e)
            c_F3_BEQ:  w_cond =  w_flag_z;
            c_F3_BNE:  w_cond = ~w_flag_z;
            c_F3_BLT:  w_cond =  (w_flag_n ^ w_flag_v);
            c_F3_BGE:  w_cond = ~(w_flag_n ^ w_flag_v);
            c_F3_BLTU: w_cond = ~w_flag_c;
            c_F3_BGEU: w_cond =  w_flag_c;
            default:   w_cond = 1'b0;
        endcase
    end

    // An op only acts when it actually advances this cycle and is not the
    // wrong-path op sitting behind a taken branch.
    assign w_act       = bus.valid_e & ~bus.stall_m & ~bus.flush &
                         (r_state == ST_IDLE);
    assign w_resolve   = w_act & (bus.branch_e | bus.jump_e);
    assign w_taken     = w_act & (bus.jump_e | (bus.branch_e & w_cond));
    assign w_br_sat    = &r_br_count;
    assign w_taken_sat = &r_taken_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_valid_m     <= 1'b0;
            r_aluresult_m <= '0;
            r_writedata_m <= '0;
            r_rd_m        <= '0;
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_resultsrc_m <= '0;
            r_redirect_m  <= 1'b0;
            r_pctarget_m  <= '0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (bus.flush) begin
            // Kill the MEM op and any pending redirect; payload data bits
            // are left as-is since they are meaningless without valid_m.
            r_state      <= ST_IDLE;
            r_valid_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_redirect_m <= 1'b0;
        end else if (bus.stall_m) begin
            // Everything holds except the redirect, which must not repeat.
            r_redirect_m <= 1'b0;
        end else begin
            r_valid_m     <= w_act;
            r_aluresult_m <= bus.aluresult_e;
            r_writedata_m <= bus.writedata_e;
            r_rd_m        <= bus.rd_e;
            r_regwrite_m  <= bus.regwrite_e & w_act;
            r_memwrite_m  <= bus.memwrite_e & w_act;
            r_resultsrc_m <= bus.resultsrc_e;
            r_redirect_m  <= w_taken;

            if (w_taken) begin
                r_pctarget_m <= bus.pctarget_e;
            end

            if (w_resolve && !w_br_sat) begin
                r_br_count <= r_br_count + c_CNT_ONE;
            end
            if (w_taken && !w_taken_sat) begin
                r_taken_count <= r_taken_count + c_CNT_ONE;
            end

            // SQUASH lasts exactly one advancing cycle: the op presented
            // in that cycle is the wrong-path op and was dropped above.
            case (r_state)
                ST_IDLE:   r_state <= w_taken ? ST_SQUASH : ST_IDLE;
                ST_SQUASH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid_m     = r_valid_m;
    assign bus.aluresult_m = r_aluresult_m;
    assign bus.writedata_m = r_writedata_m;
    assign bus.rd_m        = r_rd_m;
    assign bus.regwrite_m  = r_regwrite_m;
    assign bus.memwrite_m  = r_memwrite_m;
    assign bus.resultsrc_m = r_resultsrc_m;
    assign bus.redirect_m  = r_redirect_m;
    assign bus.pctarget_m  = r_pctarget_m;
    assign bus.br_count    = r_br_count;
    assign bus.taken_count = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_branch_stage
//  Description : Self-checking bench for ex_branch_stage. Each driven cycle
//                is run through a reference model whose expected outputs are
//                queued, then popped and compared after the clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_branch_stage;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_branch_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    ex_branch_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          rst;
        logic          valid;
        logic [DW-1:0] alu;
        logic [3:0]    flags;
        logic          br;
        logic          jmp;
        logic [2:0]    f3;
        logic [DW-1:0] pct;
        logic [DW-1:0] wd;
        logic [4:0]    rd;
        logic          rw;
        logic          mw;
        logic [1:0]    rs;
        logic          stall;
        logic          flush;
    } stim_t;

    typedef struct {
        logic          valid;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [4:0]    rd;
        logic          rw;
        logic          mw;
        logic [1:0]    rs;
        logic          redir;
        logic [DW-1:0] pct;
        int            brc;
        int            tkc;
        bit            pay_known;
        bit            pct_known;
    } exp_t;

    exp_t q[$];
    exp_t m;          // reference model state (what the outputs should be)
    bit   m_squash;   // model: next advancing op is the wrong-path op

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic br_cond(input logic [2:0] f3, input logic [3:0] fl);
        logic v, c, n, z, lt;
        v = fl[3]; c = fl[2]; n = fl[1]; z = fl[0];
        lt = n ^ v;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return !c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input stim_t s);
        logic act, taken;
        if (s.rst) begin
            m.valid = 0; m.alu = '0; m.wd = '0; m.rd = '0; m.rw = 0; m.mw = 0;
            m.rs = '0; m.redir = 0; m.pct = '0; m.brc = 0; m.tkc = 0;
            m.pay_known = 1; m.pct_known = 1; m_squash = 0;
            return;
        end
        act   = s.valid && !s.stall && !s.flush && !m_squash;
        taken = act && (s.jmp || (s.br && br_cond(s.f3, s.flags)));
        if (s.flush) begin
            m.valid = 0; m.rw = 0; m.mw = 0; m.redir = 0;
            m.pay_known = 0; m.pct_known = 0; m_squash = 0;
        end else if (s.stall) begin
            m.redir = 0;
        end else begin
            m.valid = act;
            m.alu = s.alu; m.wd = s.wd; m.rd = s.rd; m.rs = s.rs;
            m.rw = s.rw && act;
            m.mw = s.mw && act;
            m.pay_known = 1;
            m.redir = taken;
            if (taken) begin
                m.pct = s.pct;
                m.pct_known = 1;
            end
            if (act && (s.br || s.jmp) && m.brc < CNT_MAX) m.brc++;
            if (taken && m.tkc < CNT_MAX) m.tkc++;
            m_squash = m_squash ? 1'b0 : taken;
        end
    endtask

    // Drive one cycle, queue the expectation, then compare after the edge.
    task automatic apply(input stim_t s);
        exp_t e;
        reset           = s.rst;
        bus.valid_e     = s.valid;
        bus.aluresult_e = s.alu;
        bus.flags_e     = s.flags;
        bus.branch_e    = s.br;
        bus.jump_e      = s.jmp;
        bus.funct3_e    = s.f3;
        bus.pctarget_e  = s.pct;
        bus.writedata_e = s.wd;
        bus.rd_e        = s.rd;
        bus.regwrite_e  = s.rw;
        bus.memwrite_e  = s.mw;
        bus.resultsrc_e = s.rs;
        bus.stall_m     = s.stall;
        bus.flush       = s.flush;
        model_step(s);
        q.push_back(m);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check_eq("valid_m",    {31'd0, bus.valid_m},    {31'd0, e.valid});
        check_eq("regwrite_m", {31'd0, bus.regwrite_m}, {31'd0, e.rw});
        check_eq("memwrite_m", {31'd0, bus.memwrite_m}, {31'd0, e.mw});
        check_eq("redirect_m", {31'd0, bus.redirect_m}, {31'd0, e.redir});
        check_eq("br_count",    32'(bus.br_count),    32'(e.brc));
        check_eq("taken_count", 32'(bus.taken_count), 32'(e.tkc));
        if (e.pay_known) begin
            check_eq("aluresult_m", bus.aluresult_m, e.alu);
            check_eq("writedata_m", bus.writedata_m, e.wd);
            check_eq("rd_m",        {27'd0, bus.rd_m},        {27'd0, e.rd});
            check_eq("resultsrc_m", {30'd0, bus.resultsrc_m}, {30'd0, e.rs});
        end
        if (e.pct_known) begin
            check_eq("pctarget_m", bus.pctarget_m, e.pct);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.rst = 0; s.valid = 0; s.alu = '0; s.flags = '0; s.br = 0; s.jmp = 0;
        s.f3 = '0; s.pct = '0; s.wd = '0; s.rd = '0; s.rw = 0; s.mw = 0;
        s.rs = '0; s.stall = 0; s.flush = 0;
        return s;
    endfunction

    function automatic stim_t op_alu(input logic [DW-1:0] alu, input logic [4:0] rd);
        stim_t s;
        s = nop();
        s.valid = 1; s.alu = alu; s.rd = rd; s.rw = 1; s.rs = 2'd0;
        s.wd = alu ^ 32'hA5A5_0000;
        return s;
    endfunction

    function automatic stim_t op_br(input logic [2:0] f3, input logic [3:0] fl,
                                    input logic [DW-1:0] pct);
        stim_t s;
        s = nop();
        s.valid = 1; s.br = 1; s.f3 = f3; s.flags = fl; s.pct = pct;
        s.alu = 32'h0000_0BAD; s.rd = 5'd0;
        return s;
    endfunction

    function automatic stim_t op_jal(input logic [DW-1:0] pct, input logic [4:0] rd);
        stim_t s;
        s = nop();
        s.valid = 1; s.jmp = 1; s.pct = pct; s.rd = rd; s.rw = 1; s.rs = 2'd2;
        s.alu = pct + 32'd4;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        stim_t s;
        m_squash = 0;

        // Reset state
        s = nop(); s.rst = 1;
        apply(s);
        apply(s);

        // 1: beq taken (z=1), following op squashed, then normal op
        apply(op_br(3'b000, 4'b0001, 32'h100));
        s = op_alu(32'h1111, 5'd3); s.mw = 1;
        apply(s);
        apply(op_alu(32'h2222, 5'd4));

        // 2: blt with n=1,v=0 taken; bge same flags not taken
        apply(op_br(3'b100, 4'b0010, 32'h200));
        apply(op_alu(32'h3333, 5'd5));
        apply(op_br(3'b101, 4'b0010, 32'h204));
        apply(op_alu(32'h4444, 5'd6));

        // 3: bltu c=0 taken, bgeu c=1 taken, bne z=1 not taken
        apply(op_br(3'b110, 4'b0000, 32'h300));
        apply(op_alu(32'h5555, 5'd7));
        apply(op_br(3'b111, 4'b0100, 32'h304));
        apply(op_alu(32'h6666, 5'd8));
        apply(op_br(3'b001, 4'b0001, 32'h308));
        apply(op_br(3'b010, 4'b0001, 32'h30C));   // reserved funct3: not taken
        apply(op_alu(32'h7777, 5'd9));

        // 4: taken jal followed by a 3-cycle stall
        apply(op_jal(32'h400, 5'd1));
        for (int i = 0; i < 3; i++) begin
            s = op_alu(32'h8000 + i, 5'd10); s.stall = 1;
            apply(s);
        end
        apply(op_alu(32'h9999, 5'd11));            // wrong-path op, dropped
        apply(op_alu(32'hAAAA, 5'd12));

        // 5: flush during SQUASH, then normal op advances
        apply(op_br(3'b000, 4'b0001, 32'h500));
        s = op_alu(32'hBBBB, 5'd13); s.flush = 1;
        apply(s);
        apply(op_alu(32'hCCCC, 5'd14));
        // reset mid-stream, including mid-SQUASH
        apply(op_jal(32'h600, 5'd2));
        s = op_alu(32'hDDDD, 5'd15); s.rst = 1;
        apply(s);
        apply(op_alu(32'hEEEE, 5'd16));

        // 6: 20 taken jumps, counters saturate without wrapping
        s = nop(); s.rst = 1;
        apply(s);
        for (int i = 0; i < 20; i++) begin
            apply(op_jal(32'h1000 + 32'(i) * 4, 5'd1));
            apply(op_alu(32'(i), 5'd2));
        end
        check_eq("br_sat",    32'(bus.br_count),    32'(CNT_MAX));
        check_eq("taken_sat", 32'(bus.taken_count), 32'(CNT_MAX));

        // Randomised mix under occasional stall/flush
        s = nop(); s.rst = 1;
        apply(s);
        for (int i = 0; i < 60; i++) begin
            s = nop();
            s.valid = 1'($urandom_range(0, 3) != 0);
            s.br    = 1'($urandom_range(0, 2) == 0);
            s.jmp   = !s.br && ($urandom_range(0, 5) == 0);
            s.f3    = 3'($urandom_range(0, 7));
            s.flags = 4'($urandom_range(0, 15));
            s.pct   = $urandom;
            s.alu   = $urandom;
            s.wd    = $urandom;
            s.rd    = 5'($urandom_range(0, 31));
            s.rw    = 1'($urandom_range(0, 1));
            s.mw    = 1'($urandom_range(0, 1));
            s.rs    = 2'($urandom_range(0, 3));
            s.stall = 1'($urandom_range(0, 5) == 0);
            s.flush = 1'($urandom_range(0, 11) == 0);
            apply(s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
